// File: rtl/seg_scan_if.sv
// Write/display bundle between a host and the 4-digit scan driver.
// The host side is master; the driver side is slave.
interface seg_scan_if;
  logic        Wr_en;
  logic [15:0] Wr_data;
  logic        Blank_en;
  logic [3:0]  Digit;
  logic [3:0]  Anode;
  logic        Upd_pending;

  modport master (
    output Wr_en, Wr_data, Blank_en,
    input  Digit, Anode, Upd_pending
  );

  modport slave (
    input  Wr_en, Wr_data, Blank_en,
    output Digit, Anode, Upd_pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode seven-segment scan driver.
// New values latch only at frame boundaries; optional leading-zero blanking.
module seg_scan_driver #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      disp;
  logic [15:0]      pend;
  logic             pflag;

  logic tick;
  logic bnd;

  assign tick = (cnt == CNT_W'(DIV - 1));
  assign bnd  = tick && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      disp  <= 16'h0000;
      pend  <= 16'h0000;
      pflag <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick)
        idx <= idx + 2'd1;
      // A write landing on the boundary bypasses pend entirely.
      if (bnd) begin
        if (bus.Wr_en)
          disp <= bus.Wr_data;
        else if (pflag)
          disp <= pend;
        pflag <= 1'b0;
      end else if (bus.Wr_en) begin
        pend  <= bus.Wr_data;
        pflag <= 1'b1;
      end
    end
  end

  logic z3, z2, z1;
  logic blank;

  assign z3 = (disp[15:12] == 4'h0);
  assign z2 = z3 && (disp[11:8] == 4'h0);
  assign z1 = z2 && (disp[7:4] == 4'h0);

  always_comb begin
    bus.Digit = 4'h0;
    blank     = 1'b0;
    unique case (idx)
      2'd0: begin
        bus.Digit = disp[3:0];
      end
      2'd1: begin
        bus.Digit = disp[7:4];
        blank     = z1;
      end
      2'd2: begin
        bus.Digit = disp[11:8];
        blank     = z2;
      end
      2'd3: begin
        bus.Digit = disp[15:12];
        blank     = z3;
      end
    endcase
  end

  assign bus.Anode = (bus.Blank_en && blank) ? 4'b1111
                                             : ~(4'b0001 << idx);

  assign bus.Upd_pending = pflag;

endmodule
